sdcard_seq_multi: RTL and testbench
===================================

SDCARD_SEQ_MULTI -- requirements
Module: sdcard_seq_multi

Interface
REQ-001 Parameter NUM_SLOTS, default 2: number of independent SD slots, legal range 1..4.
REQ-002 Parameter POWERDOWN_BITS, default 12: power-off dwell is 2^POWERDOWN_BITS clocks.
REQ-003 Parameter POWERUP_BITS, default 12: power-on settle is 2^POWERUP_BITS clocks.
REQ-004 Parameter STARTUP_CLKS, default 80: number of in_sck rising edges issued with CS high before READY.
REQ-005 Parameter DEBOUNCE_BITS, default 16: card-detect stable time is 2^DEBOUNCE_BITS clocks.
REQ-006 The block SHALL use one clock, clk_peripheral, and one asynchronous active-low reset, resetn.
REQ-007 clk_peripheral  in  1  system clock; all state changes on its rising edge.
REQ-008 resetn  in  1  asynchronous, active-low reset.
REQ-009 in_sck / in_mosi  in  1 each; in_miso  out  1  upstream SPI master bus.
REQ-010 out_sck / out_mosi  out  1 each; out_miso  in  1  downstream SPI passthrough.
REQ-011 enable_n  in  NUM_SLOTS  per-slot chip select, active low.
REQ-012 cycle_req  in  NUM_SLOTS  single-clock pulse; forces a power cycle of that slot.
REQ-013 sd_cd / sd_wp / sd_dat0  in  NUM_SLOTS each  card detect (low = present), write protect, card MISO.
REQ-014 sd_reset_n / sd_sck / sd_cmd / sd_dat3  out  NUM_SLOTS each  power-off (1 = off), clock, MOSI, CS.
REQ-015 sd_dat1 / sd_dat2  out  NUM_SLOTS each  SHALL be constant 1.
REQ-016 slot_ready / slot_present / slot_wp  out  NUM_SLOTS each  status.

Function
REQ-017 out_sck and out_mosi SHALL equal in_sck and in_mosi combinationally.
REQ-018 sd_cd and sd_wp SHALL pass a 2-flop synchroniser; slot_present SHALL change only after the synchronised sd_cd is stable for 2^DEBOUNCE_BITS consecutive clocks.
REQ-019 Per-slot FSM states: OFF, PWRDN, PWRUP, STARTUP, READY.
REQ-020 OFF -> PWRDN when slot_present=1.
REQ-021 PWRDN -> PWRUP and PWRUP -> STARTUP after exactly 2^BITS clocks: the counter loads all-ones on entry and the transition occurs on the edge where the counter is 0.
REQ-022 STARTUP -> READY on the clock after the STARTUP_CLKS-th in_sck rising edge. Edges are detected on synchronised in_sck, so in_sck SHALL be no faster than clk_peripheral/4.
REQ-023 Any state -> OFF when slot_present falls; this has priority over all other transitions.
REQ-024 Any state except OFF -> PWRDN on cycle_req; cycle_req in OFF SHALL be ignored.
REQ-025 sd_reset_n SHALL be 1 in OFF and PWRDN, and 0 otherwise.
REQ-026 sd_sck SHALL equal in_sck in STARTUP and READY, and be 0 otherwise.
REQ-027 sd_cmd SHALL be 1 in STARTUP, in_mosi in READY, and 0 otherwise.
REQ-028 sd_dat3 SHALL be 1 in STARTUP, enable_n[i] in READY, and 0 otherwise.
REQ-029 slot_ready[i] SHALL be 1 only in READY; slot_wp SHALL be the synchronised sd_wp gated by slot_present.
REQ-030 in_miso SHALL be sd_dat0[k], where k is the lowest index with enable_n[k]=0 and slot_ready[k]=1; when no such k exists, in_miso SHALL be out_miso.
REQ-031 Slots SHALL sequence independently; simultaneous insertion of several slots SHALL proceed in parallel.

Reset
REQ-032 Asserting resetn SHALL put every FSM in OFF, zero slot_present/slot_ready/slot_wp, clear the synchronisers and debouncers, and drive sd_reset_n to all ones.
REQ-033 Reset mid-operation SHALL take effect asynchronously; sd_sck, sd_cmd and sd_dat3 SHALL be 0 while resetn is low.

Structure
REQ-034 The FSM state encoding and the OFF/PWRDN/PWRUP/STARTUP/READY constants SHALL live in a shared package, sdcard_pkg.
REQ-035 A sub-module sdcard_slot SHALL hold one slot's synchronisers, debounce, FSM and counters, and be instantiated NUM_SLOTS times.
REQ-036 The top level SHALL hold only the in_sck synchroniser, edge detect and the MISO mux.

Verification (NUM_SLOTS=2, POWERDOWN_BITS=POWERUP_BITS=4, STARTUP_CLKS=8, DEBOUNCE_BITS=3, in_sck = clk/8)
REQ-037 Scenario: sd_cd[0] low from reset release -> slot_present[0] rises 8 clocks after sync; PWRDN and PWRUP each last 16 clocks; READY follows the 8th sck edge; sd_dat3[0]=1 throughout STARTUP.
REQ-038 Scenario: sd_cd[0] glitch low for 5 clocks -> slot_present stays 0 and sd_reset_n[0] stays 1.
REQ-039 Scenario: slot 0 READY, cycle_req[0] pulse -> slot_ready[0] drops the next clock, sd_reset_n[0]=1 for 16 clocks, then the full sequence repeats; slot 1 is unaffected.
REQ-040 Scenario: both slots READY, enable_n=2'b00 -> in_miso follows sd_dat0[0]; enable_n=2'b01 -> sd_dat0[1]; enable_n=2'b11 -> out_miso.
REQ-041 Scenario: card removal during STARTUP -> OFF after debounce, sd_sck[0]=0, sd_reset_n[0]=1.
REQ-042 Scenario: resetn pulsed low during PWRUP -> all outputs reach their reset values with no clock edge.

Source files
------------

// File: rtl/sdcard_pkg.sv
// Shared definitions for the multi-slot SD card power/startup sequencer.
package sdcard_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] OFF     = 3'd0;
    localparam logic [2:0] PWRDN   = 3'd1;
    localparam logic [2:0] PWRUP   = 3'd2;
    localparam logic [2:0] STARTUP = 3'd3;
    localparam logic [2:0] READY   = 3'd4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdcard_slot.sv
// One SD slot: card-detect/write-protect synchronisers, card-detect debounce,
// power sequencing FSM and the per-slot SPI pin drive.
module sdcard_slot
    import sdcard_pkg::*;
#(
    parameter int POWERDOWN_BITS = 12,
    parameter int POWERUP_BITS   = 12,
    parameter int STARTUP_CLKS   = 80,
    parameter int DEBOUNCE_BITS  = 16
) (
    input  logic   clk_peripheral,
    input  logic   resetn,
    input  logic   sd_cd,
    input  logic   sd_wp,
    input  logic   cycle_req,
    input  logic   sck_rise,
    input  logic   in_sck,
    input  logic   in_mosi,
    input  logic   enable_n,
    output logic   sd_reset_n,
    output logic   sd_sck,
    output logic   sd_cmd,
    output logic   sd_dat3,
    output logic   ready,
    output logic   present,
    output logic   wp,
    output state_t state
);

    localparam int CNT_W = max_int(POWERDOWN_BITS, POWERUP_BITS);
    localparam int SCK_W = $clog2(STARTUP_CLKS + 1);
    localparam logic [CNT_W-1:0] PD_LOAD  = CNT_W'((64'd1 << POWERDOWN_BITS) - 64'd1);
    localparam logic [CNT_W-1:0] PU_LOAD  = CNT_W'((64'd1 << POWERUP_BITS) - 64'd1);
    localparam logic [SCK_W-1:0] SCK_LAST = SCK_W'(STARTUP_CLKS - 1);

    logic                     cd_meta, cd_sync;
    logic                     wp_meta, wp_sync;
    logic [DEBOUNCE_BITS-1:0] db_cnt;
    logic [CNT_W-1:0]         pwr_cnt;
    logic [SCK_W-1:0]         sck_cnt;
    logic                     card_in;

    // Card-detect flops idle at the "no card" level so reset never fakes an insertion.
    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            cd_meta <= 1'b1;
            cd_sync <= 1'b1;
            wp_meta <= 1'b0;
            wp_sync <= 1'b0;
        end else begin
            cd_meta <= sd_cd;
            cd_sync <= cd_meta;
            wp_meta <= sd_wp;
            wp_sync <= wp_meta;
        end
    end

    assign card_in = ~cd_sync;

    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            present <= 1'b0;
            db_cnt  <= '0;
        end else if (card_in == present) begin
            db_cnt <= '0;
        end else if (db_cnt == '1) begin
            present <= card_in;
            db_cnt  <= '0;
        end else begin
            db_cnt <= db_cnt + DEBOUNCE_BITS'(1);
        end
    end

    // Removal beats everything; a power-cycle request only matters once powered.
    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            state   <= OFF;
            pwr_cnt <= '0;
            sck_cnt <= '0;
        end else if (!present) begin
            state <= OFF;
        end else if (cycle_req && state != OFF) begin
            state   <= PWRDN;
            pwr_cnt <= PD_LOAD;
        end else begin
            case (state)
                OFF: begin
                    state   <= PWRDN;
                    pwr_cnt <= PD_LOAD;
                end
                PWRDN: begin
                    if (pwr_cnt == '0) begin
                        state   <= PWRUP;
                        pwr_cnt <= PU_LOAD;
                    end else begin
                        pwr_cnt <= pwr_cnt - CNT_W'(1);
                    end
                end
                PWRUP: begin
                    if (pwr_cnt == '0) begin
                        state   <= STARTUP;
                        sck_cnt <= '0;
                    end else begin
                        pwr_cnt <= pwr_cnt - CNT_W'(1);
                    end
                end
                STARTUP: begin
                    if (sck_rise) begin
                        if (sck_cnt == SCK_LAST) begin
                            state <= READY;
                        end
                        sck_cnt <= sck_cnt + SCK_W'(1);
                    end
                end
                READY: begin
                    state <= READY;
                end
                default: begin
                    state <= OFF;
                end
            endcase
        end
    end

    always_comb begin
        sd_reset_n = (state == OFF) || (state == PWRDN);
        sd_sck     = 1'b0;
        sd_cmd     = 1'b0;
        sd_dat3    = 1'b0;
        case (state)
            STARTUP: begin
                sd_sck  = in_sck;
                sd_cmd  = 1'b1;
                sd_dat3 = 1'b1;
            end
            READY: begin
                sd_sck  = in_sck;
                sd_cmd  = in_mosi;
                sd_dat3 = enable_n;
            end
            default: begin
                sd_sck = 1'b0;
            end
        endcase
    end

    assign ready = (state == READY);
    assign wp    = wp_sync & present;

endmodule

// File: rtl/sdcard_seq_multi.sv
// Multi-slot SD sequencer top: upstream SCK synchroniser/edge detect, per-slot
// sequencers and the MISO return mux.
module sdcard_seq_multi
    import sdcard_pkg::*;
#(
    parameter int NUM_SLOTS      = 2,
    parameter int POWERDOWN_BITS = 12,
    parameter int POWERUP_BITS   = 12,
    parameter int STARTUP_CLKS   = 80,
    parameter int DEBOUNCE_BITS  = 16
) (
    input  logic                 clk_peripheral,
    input  logic                 resetn,
    input  logic                 in_sck,
    input  logic                 in_mosi,
    output logic                 in_miso,
    output logic                 out_sck,
    output logic                 out_mosi,
    input  logic                 out_miso,
    input  logic [NUM_SLOTS-1:0] enable_n,
    input  logic [NUM_SLOTS-1:0] cycle_req,
    input  logic [NUM_SLOTS-1:0] sd_cd,
    input  logic [NUM_SLOTS-1:0] sd_wp,
    input  logic [NUM_SLOTS-1:0] sd_dat0,
    output logic [NUM_SLOTS-1:0] sd_reset_n,
    output logic [NUM_SLOTS-1:0] sd_sck,
    output logic [NUM_SLOTS-1:0] sd_cmd,
    output logic [NUM_SLOTS-1:0] sd_dat3,
    output logic [NUM_SLOTS-1:0] sd_dat1,
    output logic [NUM_SLOTS-1:0] sd_dat2,
    output logic [NUM_SLOTS-1:0] slot_ready,
    output logic [NUM_SLOTS-1:0] slot_present,
    output logic [NUM_SLOTS-1:0] slot_wp,
    output state_t [NUM_SLOTS-1:0] slot_state
);

    logic sck_meta, sck_sync, sck_prev;
    logic sck_rise;

    assign out_sck  = in_sck;
    assign out_mosi = in_mosi;
    assign sd_dat1  = '1;
    assign sd_dat2  = '1;

    always_ff @(posedge clk_peripheral or negedge resetn) begin
        if (!resetn) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
        end else begin
            sck_meta <= in_sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
        end
    end

    assign sck_rise = sck_sync & ~sck_prev;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        sdcard_slot #(
            .POWERDOWN_BITS (POWERDOWN_BITS),
            .POWERUP_BITS   (POWERUP_BITS),
            .STARTUP_CLKS   (STARTUP_CLKS),
            .DEBOUNCE_BITS  (DEBOUNCE_BITS)
        ) u_slot (
            .clk_peripheral (clk_peripheral),
            .resetn         (resetn),
            .sd_cd          (sd_cd[i]),
            .sd_wp          (sd_wp[i]),
            .cycle_req      (cycle_req[i]),
            .sck_rise       (sck_rise),
            .in_sck         (in_sck),
            .in_mosi        (in_mosi),
            .enable_n       (enable_n[i]),
            .sd_reset_n     (sd_reset_n[i]),
            .sd_sck         (sd_sck[i]),
            .sd_cmd         (sd_cmd[i]),
            .sd_dat3        (sd_dat3[i]),
            .ready          (slot_ready[i]),
            .present        (slot_present[i]),
            .wp             (slot_wp[i]),
            .state          (slot_state[i])
        );
    end

    // Scanning from the top down leaves the lowest selected ready slot in charge.
    always_comb begin
        in_miso = out_miso;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!enable_n[i] && slot_ready[i]) begin
                in_miso = sd_dat0[i];
            end
        end
    end

endmodule

// File: tb/tb_sdcard_seq_multi.sv
// Self-checking bench for sdcard_seq_multi with short power/debounce timers.
module tb_sdcard_seq_multi;
    import sdcard_pkg::*;

    localparam int NS = 2;

    logic            clk = 1'b0;
    logic            resetn;
    logic            in_sck, in_mosi, in_miso;
    logic            out_sck, out_mosi, out_miso;
    logic [NS-1:0]   enable_n, cycle_req, sd_cd, sd_wp, sd_dat0;
    logic [NS-1:0]   sd_reset_n, sd_sck, sd_cmd, sd_dat3, sd_dat1, sd_dat2;
    logic [NS-1:0]   slot_ready, slot_present, slot_wp;
    state_t [NS-1:0] slot_state;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    typedef struct {
        logic [1:0] en;
        logic [1:0] dat0;
        logic       omiso;
        logic       mosi;
        logic       sck;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    sdcard_seq_multi #(
        .NUM_SLOTS      (NS),
        .POWERDOWN_BITS (4),
        .POWERUP_BITS   (4),
        .STARTUP_CLKS   (8),
        .DEBOUNCE_BITS  (3)
    ) dut (
        .clk_peripheral (clk),
        .resetn         (resetn),
        .in_sck         (in_sck),
        .in_mosi        (in_mosi),
        .in_miso        (in_miso),
        .out_sck        (out_sck),
        .out_mosi       (out_mosi),
        .out_miso       (out_miso),
        .enable_n       (enable_n),
        .cycle_req      (cycle_req),
        .sd_cd          (sd_cd),
        .sd_wp          (sd_wp),
        .sd_dat0        (sd_dat0),
        .sd_reset_n     (sd_reset_n),
        .sd_sck         (sd_sck),
        .sd_cmd         (sd_cmd),
        .sd_dat3        (sd_dat3),
        .sd_dat1        (sd_dat1),
        .sd_dat2        (sd_dat2),
        .slot_ready     (slot_ready),
        .slot_present   (slot_present),
        .slot_wp        (slot_wp),
        .slot_state     (slot_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Seven full sck periods, then the eighth rising edge with its sync latency.
    task automatic do_startup(input logic [1:0] rdy_before, input logic [1:0] rdy_after);
        for (int p = 0; p < 7; p++) begin
            in_sck = 1'b1;
            tick(4);
            in_sck = 1'b0;
            tick(4);
        end
        check("ready_after_7_edges", slot_ready, rdy_before);
        check("dat3_in_startup", sd_dat3, 2'b11);
        in_sck = 1'b1;
        tick(2);
        check("ready_2clk_after_8th", slot_ready, rdy_before);
        tick(1);
        check("ready_3clk_after_8th", slot_ready, rdy_after);
        tick(1);
        in_sck = 1'b0;
        tick(4);
    endtask

    task automatic power_cycle0();
        cycle_req = 2'b01;
        tick(1);
        cycle_req = 2'b00;
        check("cyc_ready_drop", slot_ready, 2'b10);
        check("cyc_reset_n_on", sd_reset_n, 2'b01);
        tick(15);
        check("cyc_reset_n_15", sd_reset_n, 2'b01);
        tick(1);
        check("cyc_reset_n_16", sd_reset_n, 2'b00);
        check("cyc_state_pwrup", slot_state, {READY, PWRUP});
        tick(15);
        check("cyc_dat3_pwrup", sd_dat3, 2'b10);
        tick(1);
        check("cyc_dat3_startup", sd_dat3, 2'b11);
        check("cyc_slot1_ready", slot_ready, 2'b10);
    endtask

    initial begin
        logic       bad;
        logic [4:0] got;

        vecs[0] = '{en: 2'b00, dat0: 2'b01, omiso: 1'b0, mosi: 1'b1, sck: 1'b0, exp: 5'b1_11_00};
        vecs[1] = '{en: 2'b00, dat0: 2'b10, omiso: 1'b1, mosi: 1'b0, sck: 1'b1, exp: 5'b0_00_00};
        vecs[2] = '{en: 2'b10, dat0: 2'b01, omiso: 1'b0, mosi: 1'b1, sck: 1'b1, exp: 5'b1_11_10};
        vecs[3] = '{en: 2'b10, dat0: 2'b10, omiso: 1'b1, mosi: 1'b0, sck: 1'b0, exp: 5'b0_00_10};
        vecs[4] = '{en: 2'b01, dat0: 2'b10, omiso: 1'b0, mosi: 1'b1, sck: 1'b0, exp: 5'b1_11_01};
        vecs[5] = '{en: 2'b01, dat0: 2'b01, omiso: 1'b1, mosi: 1'b0, sck: 1'b1, exp: 5'b0_00_01};
        vecs[6] = '{en: 2'b11, dat0: 2'b11, omiso: 1'b0, mosi: 1'b1, sck: 1'b0, exp: 5'b0_11_11};
        vecs[7] = '{en: 2'b11, dat0: 2'b00, omiso: 1'b1, mosi: 1'b0, sck: 1'b1, exp: 5'b1_00_11};

        resetn    = 1'b0;
        in_sck    = 1'b0;
        in_mosi   = 1'b0;
        out_miso  = 1'b0;
        enable_n  = 2'b11;
        cycle_req = 2'b00;
        sd_cd     = 2'b11;
        sd_wp     = 2'b00;
        sd_dat0   = 2'b00;
        tick(2);
        check("rst_present", slot_present, 2'b00);
        check("rst_ready", slot_ready, 2'b00);
        check("rst_reset_n", sd_reset_n, 2'b11);
        check("rst_dat12", {sd_dat1, sd_dat2}, 4'b1111);
        check("rst_state", slot_state, {OFF, OFF});

        // Short card-detect glitch must not be accepted.
        resetn = 1'b1;
        tick(3);
        sd_cd = 2'b10;
        tick(5);
        sd_cd = 2'b11;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (slot_present !== 2'b00 || sd_reset_n !== 2'b11) bad = 1'b1;
        end
        check("glitch_ignored", bad, 1'b0);

        // Both cards present from reset release: parallel full sequence.
        resetn = 1'b0;
        sd_cd  = 2'b00;
        sd_wp  = 2'b10;
        tick(2);
        check("rst2_present", slot_present, 2'b00);
        resetn = 1'b1;
        tick(9);
        check("present_edge9", slot_present, 2'b00);
        check("wp_gated", slot_wp, 2'b00);
        tick(1);
        check("present_edge10", slot_present, 2'b11);
        check("wp_present", slot_wp, 2'b10);
        tick(1);
        check("state_pwrdn", slot_state, {PWRDN, PWRDN});
        tick(15);
        check("reset_n_pwrdn_end", sd_reset_n, 2'b11);
        tick(1);
        check("reset_n_pwrup", sd_reset_n, 2'b00);
        check("state_pwrup", slot_state, {PWRUP, PWRUP});
        tick(15);
        check("dat3_pwrup_end", sd_dat3, 2'b00);
        tick(1);
        check("dat3_startup", sd_dat3, 2'b11);
        check("cmd_startup", sd_cmd, 2'b11);
        check("sck_startup_idle", sd_sck, 2'b00);
        do_startup(2'b00, 2'b11);
        check("reset_n_ready", sd_reset_n, 2'b00);

        // MISO mux and READY pin drive via scoreboard queue.
        for (int i = 0; i < 8; i++) begin
            enable_n = vecs[i].en;
            sd_dat0  = vecs[i].dat0;
            out_miso = vecs[i].omiso;
            in_mosi  = vecs[i].mosi;
            in_sck   = vecs[i].sck;
            exp_q.push_back(vecs[i].exp);
            #1;
            got = {in_miso, sd_cmd, sd_dat3};
            check("miso_vec", got, exp_q.pop_front());
            check("passthru_vec", {out_sck, out_mosi}, {vecs[i].sck, vecs[i].mosi});
            tick(1);
        end
        enable_n = 2'b11;
        in_mosi  = 1'b0;
        in_sck   = 1'b0;
        tick(4);

        // Power cycle slot 0 while slot 1 stays ready.
        power_cycle0();
        do_startup(2'b10, 2'b11);

        // Card removal during STARTUP.
        power_cycle0();
        in_sck = 1'b1;
        sd_cd  = 2'b01;
        #1;
        check("rm_sck_startup", sd_sck, 2'b11);
        tick(9);
        check("rm_present_9", slot_present, 2'b11);
        tick(1);
        check("rm_present_10", slot_present, 2'b10);
        tick(1);
        check("rm_sck_off", sd_sck, 2'b10);
        check("rm_reset_n_off", sd_reset_n, 2'b01);
        check("rm_state_off", slot_state, {READY, OFF});
        check("rm_ready", slot_ready, 2'b10);

        // Reinsert, then assert reset in the middle of PWRUP.
        sd_cd = 2'b00;
        tick(30);
        check("re_state_pwrup", slot_state, {READY, PWRUP});
        in_mosi = 1'b1;
        #1;
        check("pre_rst_cmd", sd_cmd, 2'b10);
        resetn = 1'b0;
        #1;
        check("async_reset_n", sd_reset_n, 2'b11);
        check("async_sck", sd_sck, 2'b00);
        check("async_cmd", sd_cmd, 2'b00);
        check("async_dat3", sd_dat3, 2'b00);
        check("async_status", {slot_present, slot_ready, slot_wp}, 6'b0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
